// File: rtl/regfile_ctx.sv
// Register file with shadow bank and serial context save/restore engine.
// Latency: reads combinational, writes visible next cycle; save/restore busy NREGS (NREGS-1 with ZERO_REG) cycles.
// Backpressure: while busy, writes and new save/restore requests are dropped; the control unit must stall on busy.
//
// Ports:
//   clk, reset (async active-low)       clock / reset
//   we3, wa3, wd3                       write port (IDLE only)
//   ra1/rd1, ra2/rd2                    combinational read ports
//   save, restore                       context copy requests (save wins on a tie)
//   busy, done                          operation in progress / one-cycle completion pulse
// Optional build macro: REGFILE_CTX_BYPASS_EN enables write-through forwarding onto rd1/rd2.
// NREGS must equal 2**AW.

module regfile_ctx #(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 16,
    parameter int AW       = 4,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             save,
    input  logic             restore,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2
    } state_t;

    // r0 is hardwired when ZERO_REG, so the copy loop starts at 1
    localparam logic [AW-1:0] FIRST_IDX = (ZERO_REG != 0) ? AW'(1) : AW'(0);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

    logic [WIDTH-1:0] main_q   [NREGS];
    logic [WIDTH-1:0] shadow_q [NREGS];

    state_t        state, state_nxt;
    logic [AW-1:0] idx;
    logic          done_q;
    logic          idx_last;
    logic          start_op;
    logic          wr_ok;

    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign idx_last = (idx == LAST_IDX);
    assign start_op = (state == IDLE) && (save || restore);
    assign wr_ok    = (state == IDLE) && we3 && ((ZERO_REG == 0) || (wa3 != '0));

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (save) begin
                    state_nxt = SAVE;
                end else if (restore) begin
                    state_nxt = RESTORE;
                end
            end
            SAVE, RESTORE: begin
                if (idx_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Copy index: loaded on acceptance, advanced once per transfer edge.
    // Holds at LAST_IDX rather than wrapping on the final copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (start_op) begin
            idx <= FIRST_IDX;
        end else if (busy && !idx_last) begin
            idx <= idx + AW'(1);
        end
    end

    // done pulses in the first cycle back in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= busy && idx_last;
        end
    end

    // Main bank: restore copies take the write port; architectural writes only in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                main_q[i] <= '0;
            end
        end else if (state == RESTORE) begin
            main_q[idx] <= shadow_q[idx];
        end else if (wr_ok) begin
            main_q[wa3] <= wd3;
        end
    end

    // Shadow bank: only reachable through the save engine
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (state == SAVE) begin
            shadow_q[idx] <= main_q[idx];
        end
    end

    // Read ports
    always_comb begin
        rd1 = main_q[ra1];
        rd2 = main_q[ra2];
`ifdef REGFILE_CTX_BYPASS_EN
        // wr_ok already excludes the hardwired r0 and non-IDLE cycles
        if (wr_ok && (wa3 == ra1)) begin
            rd1 = wd3;
        end
        if (wr_ok && (wa3 == ra2)) begin
            rd2 = wd3;
        end
`endif
        if ((ZERO_REG != 0) && (ra1 == '0)) begin
            rd1 = '0;
        end
        if ((ZERO_REG != 0) && (ra2 == '0)) begin
            rd2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_ctx.sv
module tb_regfile_ctx;

    logic        clk;
    logic        reset;
    logic        we3;
    logic [3:0]  wa3;
    logic [15:0] wd3;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic        save;
    logic        restore;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_bad;

    regfile_ctx #(.WIDTH(16), .NREGS(16), .AW(4), .ZERO_REG(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .we3     (we3),
        .wa3     (wa3),
        .wd3     (wd3),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd1     (rd1),
        .rd2     (rd2),
        .save    (save),
        .restore (restore),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        we3 = 1'b1;
        wa3 = a;
        wd3 = d;
        tick();
        we3 = 1'b0;
    endtask

    // counts cycles with busy observed high; bounded
    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ra1 = 4'd5;
        ra2 = 4'd5;
        #1;
        n_cmp++; if (rd1 !== 16'h0000) begin n_bad++; $display("FAIL reset_rd1 got %h want %h", rd1, 16'h0000); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        tick();
        reset = 1'b1;
        tick();
        wr(4'd5, 16'hC0DE);
        #1;
        n_cmp++; if (rd1 !== 16'hC0DE) begin n_bad++; $display("FAIL prereset_rd1 got %h want %h", rd1, 16'hC0DE); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (rd1 !== 16'h0000) begin n_bad++; $display("FAIL midcycle_reset_rd1 got %h want %h", rd1, 16'h0000); end
        n_cmp++; if (rd2 !== 16'h0000) begin n_bad++; $display("FAIL midcycle_reset_rd2 got %h want %h", rd2, 16'h0000); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL midcycle_reset_flags got busy=%b done=%b want 0/0", busy, done); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write();
        wr(4'd5, 16'hBEEF);
        ra1 = 4'd5;
        #1;
        n_cmp++; if (rd1 !== 16'hBEEF) begin n_bad++; $display("FAIL write_r5 got %h want %h", rd1, 16'hBEEF); end
        wr(4'd0, 16'h1234);
        ra1 = 4'd0;
        #1;
        n_cmp++; if (rd1 !== 16'h0000) begin n_bad++; $display("FAIL write_r0 got %h want %h", rd1, 16'h0000); end
    endtask

    task automatic test_roundtrip();
        int cnt;
        for (int i = 1; i < 16; i++) begin
            wr(4'(i), 16'(i * 16'h0101));
        end
        save = 1'b1;
        tick();
        save = 1'b0;
        wait_busy(cnt);
        n_cmp++; if (cnt !== 15) begin n_bad++; $display("FAIL save_busy_cycles got %0d want 15", cnt); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL save_done got %b want 1", done); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL save_done_width got %b want 0", done); end
        for (int i = 1; i < 16; i++) begin
            wr(4'(i), 16'hFFFF);
        end
        ra1 = 4'd7;
        ra2 = 4'd15;
        #1;
        n_cmp++; if (rd1 !== 16'hFFFF) begin n_bad++; $display("FAIL overwrite_r7 got %h want %h", rd1, 16'hFFFF); end
        restore = 1'b1;
        tick();
        restore = 1'b0;
        wait_busy(cnt);
        n_cmp++; if (cnt !== 15) begin n_bad++; $display("FAIL restore_busy_cycles got %0d want 15", cnt); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL restore_done got %b want 1", done); end
        n_cmp++; if (rd1 !== 16'h0707) begin n_bad++; $display("FAIL restore_r7 got %h want %h", rd1, 16'h0707); end
        n_cmp++; if (rd2 !== 16'h0F0F) begin n_bad++; $display("FAIL restore_r15 got %h want %h", rd2, 16'h0F0F); end
        tick();
    endtask

    task automatic test_contention();
        int cnt;
        wr(4'd3, 16'h3333);
        save = 1'b1;
        restore = 1'b1;
        tick();
        save = 1'b0;
        restore = 1'b0;
        we3 = 1'b1;
        wa3 = 4'd3;
        wd3 = 16'hAAAA;
        tick();
        save = 1'b1;
        tick();
        save = 1'b0;
        wait_busy(cnt);
        we3 = 1'b0;
        ra1 = 4'd3;
        #1;
        n_cmp++; if (cnt !== 13) begin n_bad++; $display("FAIL contention_busy_cycles got %0d want 13", cnt); end
        n_cmp++; if (rd1 !== 16'h3333) begin n_bad++; $display("FAIL busy_write_dropped got %h want %h", rd1, 16'h3333); end
        tick();
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL extra_save_ignored got busy=%b done=%b want 0/0", busy, done); end
        // shadow must hold 0x3333 if SAVE won the tie
        wr(4'd3, 16'h0000);
        restore = 1'b1;
        tick();
        restore = 1'b0;
        wait_busy(cnt);
        #1;
        n_cmp++; if (rd1 !== 16'h3333) begin n_bad++; $display("FAIL save_wins_tie got %h want %h", rd1, 16'h3333); end
        tick();
    endtask

    task automatic test_reset_mid_restore();
        int dn;
        restore = 1'b1;
        tick();
        restore = 1'b0;
        repeat (4) tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_restore_busy got %b want 1", busy); end
        #2;
        reset = 1'b0;
        ra1 = 4'd7;
        ra2 = 4'd15;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
        n_cmp++; if (rd1 !== 16'h0000 || rd2 !== 16'h0000) begin n_bad++; $display("FAIL abort_regs got %h/%h want 0000/0000", rd1, rd2); end
        tick();
        reset = 1'b1;
        dn = 0;
        repeat (3) begin
            if (done) dn++;
            tick();
        end
        n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d want 0", dn); end
        // shadow bank was cleared too
        wr(4'd7, 16'h7777);
        restore = 1'b1;
        tick();
        restore = 1'b0;
        wait_busy(dn);
        #1;
        n_cmp++; if (rd1 !== 16'h0000) begin n_bad++; $display("FAIL shadow_cleared got %h want %h", rd1, 16'h0000); end
        tick();
    endtask

    task automatic test_bypass();
        logic [15:0] exp_same;
        wr(4'd9, 16'h1111);
        ra2 = 4'd9;
        ra1 = 4'd0;
        we3 = 1'b1;
        wa3 = 4'd9;
        wd3 = 16'h5A5A;
        #1;
`ifdef REGFILE_CTX_BYPASS_EN
        exp_same = 16'h5A5A;
`else
        exp_same = 16'h1111;
`endif
        n_cmp++; if (rd2 !== exp_same) begin n_bad++; $display("FAIL bypass_same_cycle got %h want %h", rd2, exp_same); end
        tick();
        we3 = 1'b0;
        #1;
        n_cmp++; if (rd2 !== 16'h5A5A) begin n_bad++; $display("FAIL bypass_next_cycle got %h want %h", rd2, 16'h5A5A); end
        we3 = 1'b1;
        wa3 = 4'd0;
        wd3 = 16'h9999;
        #1;
        n_cmp++; if (rd1 !== 16'h0000) begin n_bad++; $display("FAIL bypass_r0 got %h want %h", rd1, 16'h0000); end
        tick();
        we3 = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        we3 = 1'b0;
        wa3 = '0;
        wd3 = '0;
        ra1 = '0;
        ra2 = '0;
        save = 1'b0;
        restore = 1'b0;
        test_reset();
        test_write();
        test_roundtrip();
        test_contention();
        test_reset_mid_restore();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_ctx.md
Name: regfile_ctx

Overview:
- Parametrised successor to the CPU's 16x16 two-read/one-write register file.
- Adds a shadow bank and a serial context save/restore engine for interrupt entry and exit, with a busy/done handshake.
- Sits in the datapath in place of the plain register file; the control unit drives save/restore and stalls on busy.

Parameters:
- WIDTH, 16, data width of each register.
- NREGS, 16, number of architectural registers; must equal 2**AW.
- AW, 4, register address width.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is skipped by save/restore.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- we3  in  1  write enable for port 3.
- wa3  in  AW  write address.
- wd3  in  WIDTH  write data.
- ra1  in  AW  read address, port 1.
- ra2  in  AW  read address, port 2.
- rd1  out  WIDTH  read data, port 1 (combinational).
- rd2  out  WIDTH  read data, port 2 (combinational).
- save  in  1  request: copy main bank to shadow bank.
- restore  in  1  request: copy shadow bank to main bank.
- busy  out  1  save/restore in progress.
- done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset (reset=0, asynchronous): all main and shadow registers cleared to 0, FSM forced to IDLE, index counter to 0, busy=0, done=0. Reset asserted mid-operation aborts it; no done pulse.
- Reads: rd1 = main[ra1], rd2 = main[ra2], combinational. With ZERO_REG=1 an address of 0 reads 0.
- Write: in IDLE with we3=1, main[wa3] <= wd3 at the edge. With ZERO_REG=1, wa3=0 is dropped.
- While busy=1, we3 is ignored: the write is dropped, not queued. The control unit must stall.
- FSM states: IDLE, SAVE, RESTORE.
  - IDLE -> SAVE when save=1.
  - IDLE -> RESTORE when restore=1 and save=0. Simultaneous save and restore: save wins.
  - save/restore asserted while not IDLE are ignored.
- Operation start: at the accepting edge E0, the index is loaded with the first index (1 if ZERO_REG else 0) and busy goes high.
- Transfer: each following edge copies one register (SAVE: shadow[idx] <= main[idx]; RESTORE: main[idx] <= shadow[idx]) and increments idx.
- Completion: on the edge that copies index NREGS-1, the FSM returns to IDLE. busy falls and done=1 for exactly one cycle.
- Latency: busy high for NREGS cycles (NREGS-1 with ZERO_REG=1). done is high in the cycle after busy falls.
- Reads during RESTORE return the partially restored bank; that is legal but the data is not architecturally meaningful.
- Index arithmetic: idx is AW bits wide. The termination compare is against NREGS-1, so idx never wraps.
- A new save/restore may be accepted in the same cycle done is high (FSM already IDLE).
- The shadow bank is not readable or writable through ports other than save/restore.

Optional Feature:
- Macro: REGFILE_CTX_BYPASS_EN.
- Defined: in IDLE, if we3=1 and wa3==ra1 (or ra2) and the address is nonzero-or-ZERO_REG=0, the matching rd port returns wd3 in the same cycle (write-through forwarding).
- Undefined: rd ports return the stored value; new data is visible the cycle after the write edge.

Test Plan:
- Reset/read: assert reset=0 mid-cycle with prior contents -> rd1=rd2=0x0000 immediately; busy=0, done=0.
- Write/read and r0: write 0xBEEF to r5 -> ra1=5 gives 0xBEEF next cycle. Write 0x1234 to r0 -> ra1=0 gives 0x0000.
- Save/restore round trip: load rN=N*0x0101, pulse save -> busy for 15 cycles, then done for 1 cycle. Overwrite all with 0xFFFF, pulse restore -> after done, r7=0x0707 and r15=0x0F0F.
- Contention: save and restore in the same cycle -> SAVE executes. we3=1 to r3 with 0xAAAA during busy -> r3 unchanged after done. A second save during busy -> no extra done pulse.
- Reset mid-RESTORE: reset=0 at the 5th busy cycle -> busy=0 immediately, all registers 0, no done pulse.
- Bypass (macro defined): we3=1, wa3=ra2=9, wd3=0x5A5A -> rd2=0x5A5A in the same cycle. Macro undefined -> old value that cycle.
